// File: rtl/ex_stage.sv
// Execute stage: forwarding, 16-bit ALU, Z/V/N flag register, load-byte merge, PC select, EX/MEM register.
// Optional feature: define EX_FWD_EN to enable EX/MEM and MEM/WB operand forwarding.
module ex_stage #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic          ALUSrc,
    input  logic          RegWrite,
    input  logic          LH,
    input  logic          HLT,
    input  logic [1:0]    MemtoReg,
    input  logic [2:0]    ALUOp,
    input  logic [2:0]    fwr,
    input  logic [DW-1:0] pc_in,
    input  logic [DW-1:0] src_rd1,
    input  logic [DW-1:0] src_rd2,
    input  logic [DW-1:0] ALUImm,
    input  logic [DW-1:0] LBImm,
    input  logic [RW-1:0] Rs,
    input  logic [RW-1:0] Rt,
    input  logic [RW-1:0] dst_reg,
    input  logic          wb_RegWrite,
    input  logic [RW-1:0] wb_dst,
    input  logic [DW-1:0] wb_data,
    output logic          exm_MemRead,
    output logic          exm_MemWrite,
    output logic          exm_RegWrite,
    output logic          exm_MemtoReg,
    output logic          exm_HLT,
    output logic [DW-1:0] exm_result,
    output logic [DW-1:0] exm_store_data,
    output logic [RW-1:0] exm_dst,
    output logic [2:0]    FLAG,
    output logic          halted
);

    logic [DW-1:0] fwd_a, fwd_b, op_b;
    logic [DW-1:0] alu_out, sum, diff, padd, result;
    logic [2*DW-1:0] rot;
    logic [8:0]    red_hi, red_lo;
    logic [9:0]    red_sum;
    logic [3:0]    shamt;
    logic          alu_v;
    logic [2:0]    new_flags;

`ifdef EX_FWD_EN
    // EX/MEM beats MEM/WB; loads sitting in EX/MEM are not forwardable here.
    always_comb begin
        fwd_a = src_rd1;
        if (exm_RegWrite && !exm_MemtoReg && exm_dst != '0 && exm_dst == Rs)
            fwd_a = exm_result;
        else if (wb_RegWrite && wb_dst != '0 && wb_dst == Rs)
            fwd_a = wb_data;
    end

    always_comb begin
        fwd_b = src_rd2;
        if (exm_RegWrite && !exm_MemtoReg && exm_dst != '0 && exm_dst == Rt)
            fwd_b = exm_result;
        else if (wb_RegWrite && wb_dst != '0 && wb_dst == Rt)
            fwd_b = wb_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{wb_RegWrite, wb_dst, wb_data, Rs, Rt};
    assign fwd_a = src_rd1;
    assign fwd_b = src_rd2;
`endif

    assign op_b  = ALUSrc ? ALUImm : fwd_b;
    assign shamt = op_b[3:0];
    assign sum   = fwd_a + op_b;
    assign diff  = fwd_a - op_b;
    assign rot   = {fwd_a, fwd_a} >> shamt;

    // Byte reduction: signed 9-bit byte sums, then a signed 10-bit total.
    assign red_hi  = {fwd_a[15], fwd_a[15:8]} + {op_b[15], op_b[15:8]};
    assign red_lo  = {fwd_a[7], fwd_a[7:0]} + {op_b[7], op_b[7:0]};
    assign red_sum = {red_hi[8], red_hi} + {red_lo[8], red_lo};

    function automatic logic [3:0] sat_add4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] s;
        s = x + y;
        if (x[3] == y[3] && s[3] != x[3])
            s = x[3] ? 4'h8 : 4'h7;
        return s;
    endfunction

    always_comb begin
        padd = '0;
        for (int i = 0; i < 4; i++)
            padd[4*i +: 4] = sat_add4(fwd_a[4*i +: 4], op_b[4*i +: 4]);
    end

    always_comb begin
        alu_out = '0;
        alu_v   = 1'b0;
        case (ALUOp)
            3'b000: begin
                alu_v   = (fwd_a[15] == op_b[15]) && (sum[15] != fwd_a[15]);
                alu_out = alu_v ? (fwd_a[15] ? 16'h8000 : 16'h7FFF) : sum;
            end
            3'b001: begin
                alu_v   = (fwd_a[15] != op_b[15]) && (diff[15] != fwd_a[15]);
                alu_out = alu_v ? (fwd_a[15] ? 16'h8000 : 16'h7FFF) : diff;
            end
            3'b010:  alu_out = fwd_a ^ op_b;
            3'b011:  alu_out = {{6{red_sum[9]}}, red_sum};
            3'b100:  alu_out = fwd_a << shamt;
            3'b101:  alu_out = $signed(fwd_a) >>> shamt;
            3'b110:  alu_out = rot[DW-1:0];
            default: alu_out = padd;
        endcase
    end

    assign new_flags = {alu_out == '0, alu_v, alu_out[15]};

    always_comb begin
        result = alu_out;
        case (MemtoReg)
            2'b10:   result = LH ? {LBImm[7:0], fwd_a[7:0]} : {fwd_a[15:8], LBImm[7:0]};
            2'b11:   result = pc_in;
            default: result = alu_out;
        endcase
    end

    // Bubbles clear only the control bits; data fields keep their old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            exm_MemRead    <= 1'b0;
            exm_MemWrite   <= 1'b0;
            exm_RegWrite   <= 1'b0;
            exm_MemtoReg   <= 1'b0;
            exm_HLT        <= 1'b0;
            exm_result     <= '0;
            exm_store_data <= '0;
            exm_dst        <= '0;
            FLAG           <= 3'b000;
            halted         <= 1'b0;
        end else if (!stall) begin
            if (flush || halted) begin
                exm_MemRead  <= 1'b0;
                exm_MemWrite <= 1'b0;
                exm_RegWrite <= 1'b0;
                exm_MemtoReg <= 1'b0;
                exm_HLT      <= 1'b0;
            end else begin
                exm_MemRead    <= MemRead;
                exm_MemWrite   <= MemWrite;
                exm_RegWrite   <= RegWrite;
                exm_MemtoReg   <= (MemtoReg == 2'b01);
                exm_HLT        <= HLT;
                exm_result     <= result;
                exm_store_data <= fwd_b;
                exm_dst        <= dst_reg;
                FLAG           <= (fwr & new_flags) | (~fwr & FLAG);
                if (HLT)
                    halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a spec-level model checked every cycle plus literal expectations.
module tb_ex_stage;

    logic        clk, rst, stall, flush;
    logic        MemRead, MemWrite, ALUSrc, RegWrite, LH, HLT;
    logic [1:0]  MemtoReg;
    logic [2:0]  ALUOp, fwr;
    logic [15:0] pc_in, src_rd1, src_rd2, ALUImm, LBImm;
    logic [3:0]  Rs, Rt, dst_reg;
    logic        wb_RegWrite;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;
    logic        exm_MemRead, exm_MemWrite, exm_RegWrite, exm_MemtoReg, exm_HLT;
    logic [15:0] exm_result, exm_store_data;
    logic [3:0]  exm_dst;
    logic [2:0]  FLAG;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    ex_stage #(.DW(16), .RW(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .LH(LH), .HLT(HLT), .MemtoReg(MemtoReg), .ALUOp(ALUOp), .fwr(fwr),
        .pc_in(pc_in), .src_rd1(src_rd1), .src_rd2(src_rd2), .ALUImm(ALUImm), .LBImm(LBImm),
        .Rs(Rs), .Rt(Rt), .dst_reg(dst_reg),
        .wb_RegWrite(wb_RegWrite), .wb_dst(wb_dst), .wb_data(wb_data),
        .exm_MemRead(exm_MemRead), .exm_MemWrite(exm_MemWrite), .exm_RegWrite(exm_RegWrite),
        .exm_MemtoReg(exm_MemtoReg), .exm_HLT(exm_HLT), .exm_result(exm_result),
        .exm_store_data(exm_store_data), .exm_dst(exm_dst), .FLAG(FLAG), .halted(halted)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid = 1'b0;
    logic        m_data_valid = 1'b0;
    logic        m_rw, m_mr, m_mw, m_m2r, m_hlt, m_halted;
    logic [15:0] m_res, m_store;
    logic [3:0]  m_dst;
    logic [2:0]  m_flag;
    logic [15:0] ma, mrt, mb, malu;
    logic        mv;

    function automatic int sx4(input logic [3:0] x);
        return int'($signed(x));
    endfunction

    function automatic int sx8(input logic [7:0] x);
        return int'($signed(x));
    endfunction

    function automatic void model_alu(input logic [2:0] op, input logic [15:0] a,
                                      input logic [15:0] b, output logic [15:0] r,
                                      output logic v);
        int sa, sb, s, amt;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        amt = int'(b[3:0]);
        r   = 16'h0000;
        v   = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                s = (op == 3'd0) ? sa + sb : sa - sb;
                if (s > 32767) begin r = 16'h7FFF; v = 1'b1; end
                else if (s < -32768) begin r = 16'h8000; v = 1'b1; end
                else r = 16'(s);
            end
            3'd2: r = a ^ b;
            3'd3: r = 16'(sx8(a[15:8]) + sx8(b[15:8]) + sx8(a[7:0]) + sx8(b[7:0]));
            3'd4: r = a << amt;
            3'd5: r = 16'(sa >>> amt);
            3'd6: begin
                r = a;
                for (int i = 0; i < amt; i++) r = {r[0], r[15:1]};
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    s = sx4(a[4*i +: 4]) + sx4(b[4*i +: 4]);
                    if (s > 7) s = 7;
                    if (s < -8) s = -8;
                    r[4*i +: 4] = 4'(s);
                end
            end
        endcase
    endfunction

    function automatic logic [15:0] model_fwd(input logic [3:0] r, input logic [15:0] rf);
        if (!FWD) return rf;
        if (m_rw && !m_m2r && r != 4'd0 && r == m_dst) return m_res;
        if (wb_RegWrite && wb_dst != 4'd0 && wb_dst == r) return wb_data;
        return rf;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            {m_rw, m_mr, m_mw, m_m2r, m_hlt, m_halted} = '0;
            m_res = 16'h0; m_store = 16'h0; m_dst = 4'h0; m_flag = 3'b000;
            m_valid = 1'b1; m_data_valid = 1'b1;
        end else if (!stall) begin
            if (flush || m_halted) begin
                {m_rw, m_mr, m_mw, m_m2r, m_hlt} = '0;
                m_data_valid = 1'b0;
            end else begin
                ma  = model_fwd(Rs, src_rd1);
                mrt = model_fwd(Rt, src_rd2);
                mb  = ALUSrc ? ALUImm : mrt;
                model_alu(ALUOp, ma, mb, malu, mv);
                if (fwr[2]) m_flag[2] = (malu == 16'h0);
                if (fwr[1]) m_flag[1] = mv;
                if (fwr[0]) m_flag[0] = malu[15];
                case (MemtoReg)
                    2'b10:   m_res = LH ? {LBImm[7:0], ma[7:0]} : {ma[15:8], LBImm[7:0]};
                    2'b11:   m_res = pc_in;
                    default: m_res = malu;
                endcase
                m_rw = RegWrite; m_mr = MemRead; m_mw = MemWrite;
                m_m2r = (MemtoReg == 2'b01); m_hlt = HLT;
                m_store = mrt; m_dst = dst_reg;
                if (HLT) m_halted = 1'b1;
                m_data_valid = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("exm_RegWrite", 16'(exm_RegWrite), 16'(m_rw));
            check("exm_MemRead", 16'(exm_MemRead), 16'(m_mr));
            check("exm_MemWrite", 16'(exm_MemWrite), 16'(m_mw));
            check("exm_MemtoReg", 16'(exm_MemtoReg), 16'(m_m2r));
            check("exm_HLT", 16'(exm_HLT), 16'(m_hlt));
            check("FLAG", 16'(FLAG), 16'(m_flag));
            check("halted", 16'(halted), 16'(m_halted));
            if (m_data_valid) begin
                check("exm_result", exm_result, m_res);
                check("exm_store_data", exm_store_data, m_store);
                check("exm_dst", 16'(exm_dst), 16'(m_dst));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] fw, input logic [3:0] d);
        stall = 1'b0; flush = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; ALUSrc = 1'b0; RegWrite = 1'b1;
        LH = 1'b0; HLT = 1'b0; MemtoReg = 2'b00;
        ALUOp = op; fwr = fw; src_rd1 = a; src_rd2 = b; dst_reg = d;
        pc_in = 16'h0; ALUImm = 16'h0; LBImm = 16'h0; Rs = 4'd0; Rt = 4'd0;
        wb_RegWrite = 1'b0; wb_dst = 4'd0; wb_data = 16'h0;
    endtask

    // ---------------- directed vectors ----------------
    initial begin
        alu_op(3'd0, 16'h0, 16'h0, 3'b000, 4'd0);
        RegWrite = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_result", exm_result, 16'h0000);
        check("rst_regwrite", 16'(exm_RegWrite), 16'd0);
        check("rst_flag", 16'(FLAG), 16'd0);
        check("rst_halted", 16'(halted), 16'd0);

        alu_op(3'd0, 16'h0003, 16'h0004, 3'b111, 4'd1); tick();
        check("add_small", exm_result, 16'h0007);
        check("add_small_flag", 16'(FLAG), 16'b000);

        alu_op(3'd0, 16'h7000, 16'h7000, 3'b111, 4'd1); tick();
        check("add_sat", exm_result, 16'h7FFF);
        check("add_sat_flag", 16'(FLAG), 16'b010);

        alu_op(3'd2, 16'h00FF, 16'h00FF, 3'b100, 4'd1); tick();
        check("xor_zero", exm_result, 16'h0000);
        check("xor_zero_flag", 16'(FLAG), 16'b110);

        alu_op(3'd1, 16'h8000, 16'h0001, 3'b111, 4'd1); tick();
        check("sub_sat", exm_result, 16'h8000);
        check("sub_sat_flag", 16'(FLAG), 16'b011);

        alu_op(3'd4, 16'h0001, 16'h0004, 3'b000, 4'd1); tick();
        check("sll", exm_result, 16'h0010);
        alu_op(3'd5, 16'h8000, 16'h0003, 3'b000, 4'd1); tick();
        check("sra", exm_result, 16'hF000);
        alu_op(3'd6, 16'h0001, 16'h0001, 3'b000, 4'd1); tick();
        check("ror", exm_result, 16'h8000);
        alu_op(3'd4, 16'hABCD, 16'h0010, 3'b000, 4'd1); tick();
        check("sll_zero_amt", exm_result, 16'hABCD);
        alu_op(3'd3, 16'h7F01, 16'h7F02, 3'b000, 4'd1); tick();
        check("red_pos", exm_result, 16'h0101);
        alu_op(3'd3, 16'h8080, 16'h8080, 3'b000, 4'd1); tick();
        check("red_neg", exm_result, 16'hFE00);
        alu_op(3'd7, 16'h7811, 16'h1811, 3'b000, 4'd1); tick();
        check("paddsb", exm_result, 16'h7822);

        // RAW through EX/MEM
        alu_op(3'd0, 16'h0001, 16'h0001, 3'b000, 4'd1); Rs = 4'd2; Rt = 4'd3; tick();
        check("raw_producer", exm_result, 16'h0002);
        alu_op(3'd1, 16'h0000, 16'h0000, 3'b000, 4'd2); Rs = 4'd1; ALUSrc = 1'b1; ALUImm = 16'h0001; tick();
        check("raw_exm_fwd", exm_result, FWD ? 16'h0001 : 16'hFFFF);

        // RAW through MEM/WB
        alu_op(3'd0, 16'h0005, 16'h0005, 3'b000, 4'd5); tick();
        alu_op(3'd1, 16'h0000, 16'h0000, 3'b000, 4'd2); Rs = 4'd1; ALUSrc = 1'b1; ALUImm = 16'h0001;
        wb_RegWrite = 1'b1; wb_dst = 4'd1; wb_data = 16'h0010; tick();
        check("raw_wb_fwd", exm_result, FWD ? 16'h000F : 16'hFFFF);

        // EX/MEM wins over MEM/WB; store data follows forwarded Rt
        alu_op(3'd0, 16'h0000, 16'h0000, 3'b000, 4'd0); Rs = 4'd2; Rt = 4'd2;
        wb_RegWrite = 1'b1; wb_dst = 4'd2; wb_data = 16'h0100; tick();
        check("fwd_priority", exm_result, FWD ? 16'h001E : 16'h0000);
        check("fwd_store", exm_store_data, FWD ? 16'h000F : 16'h0000);

        // register 0 never forwarded
        alu_op(3'd0, 16'h0005, 16'h0006, 3'b000, 4'd3);
        wb_RegWrite = 1'b1; wb_dst = 4'd0; wb_data = 16'h0999; tick();
        check("r0_no_fwd", exm_result, 16'h000B);

        // load in EX/MEM is not forwarded
        alu_op(3'd0, 16'h0100, 16'h0004, 3'b000, 4'd4); MemtoReg = 2'b01; MemRead = 1'b1; tick();
        check("lw_addr", exm_result, 16'h0104);
        check("lw_memtoreg", 16'(exm_MemtoReg), 16'd1);
        alu_op(3'd0, 16'h0020, 16'h0001, 3'b000, 4'd5); Rs = 4'd4; tick();
        check("no_fwd_from_load", exm_result, 16'h0021);

        alu_op(3'd0, 16'h0040, 16'hBEEF, 3'b000, 4'd0); RegWrite = 1'b0; MemWrite = 1'b1;
        ALUSrc = 1'b1; ALUImm = 16'h0002; tick();
        check("sw_addr", exm_result, 16'h0042);
        check("sw_data", exm_store_data, 16'hBEEF);

        alu_op(3'd0, 16'h1234, 16'h0000, 3'b000, 4'd6); MemtoReg = 2'b10; LBImm = 16'h00AB; tick();
        check("llb", exm_result, 16'h12AB);
        alu_op(3'd0, 16'h1234, 16'h0000, 3'b000, 4'd6); MemtoReg = 2'b10; LBImm = 16'h00AB; LH = 1'b1; tick();
        check("lhb", exm_result, 16'hAB34);

        alu_op(3'd0, 16'h1111, 16'h2222, 3'b000, 4'd7); MemtoReg = 2'b11; pc_in = 16'h0246; tick();
        check("pc_save", exm_result, 16'h0246);

        alu_op(3'd2, 16'h5555, 16'h5555, 3'b111, 4'd8); flush = 1'b1; tick();
        check("flush_regwrite", 16'(exm_RegWrite), 16'd0);
        check("flush_flag", 16'(FLAG), 16'b011);

        alu_op(3'd0, 16'h0011, 16'h0022, 3'b111, 4'd6); tick();
        check("pre_stall", exm_result, 16'h0033);
        for (int i = 0; i < 3; i++) begin
            alu_op(3'd2, 16'h0005, 16'h0005, 3'b111, 4'd9);
            stall = 1'b1;
            flush = (i == 2);
            tick();
            check("stall_result", exm_result, 16'h0033);
            check("stall_dst", 16'(exm_dst), 16'd6);
            check("stall_regwrite", 16'(exm_RegWrite), 16'd1);
            check("stall_flag", 16'(FLAG), 16'b000);
        end

        alu_op(3'd0, 16'h0001, 16'h0001, 3'b111, 4'd0); RegWrite = 1'b0; HLT = 1'b1; tick();
        check("hlt_exm", 16'(exm_HLT), 16'd1);
        check("hlt_halted", 16'(halted), 16'd1);
        alu_op(3'd2, 16'h0003, 16'h0003, 3'b111, 4'd1); tick();
        check("halt_regwrite", 16'(exm_RegWrite), 16'd0);
        check("halt_flag", 16'(FLAG), 16'b000);
        check("halt_sticky", 16'(halted), 16'd1);
        tick();

        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_clears_halt", 16'(halted), 16'd0);
        alu_op(3'd0, 16'h0002, 16'h0003, 3'b000, 4'd1); tick();
        check("post_reset_add", exm_result, 16'h0005);
        check("post_reset_rw", 16'(exm_RegWrite), 16'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
